fixed_point_div_ctrl: RTL
=========================

Name: fixed_point_div_ctrl

Overview:
- Upstream sequencer for the 10-bit fixed-point divider datapath.
- Accepts dividend/divisor pairs over a valid/ready handshake, then drives the divider's operand load strobes, clear and start.
- Times the fixed iteration count, captures quotient and overflow, and presents the result downstream over a second valid/ready handshake.
- Divide-by-zero is trapped locally; the divider is never started for it.

Parameters:
- WIDTH, 10, operand and quotient width.
- DIV_CYCLES, 14, divider iteration cycles from start to a stable quotient.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept a pair.
- in_a  in  WIDTH  dividend.
- in_b  in  WIDTH  divisor.
- div_A  out  WIDTH  dividend to divider A input.
- div_B  out  WIDTH  divisor to divider B input.
- div_ld_a  out  1  divider A-register load strobe.
- div_ld_b  out  1  divider B-register load strobe.
- div_clr  out  1  divider counter/ACC/Q clear pulse; the integrator ORs it with rst.
- div_start  out  1  divider start pulse.
- div_q  in  WIDTH  divider quotient (Q_next).
- div_ov  in  1  divider overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_q  out  WIDTH  quotient.
- out_ov  out  1  overflow flag.
- out_dz  out  1  divide-by-zero flag.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE; the operand registers, out_q, out_ov, out_dz and the cycle counter all go to 0.
  - All strobes and out_valid are 0. in_ready is 1 after reset release.
- State machine: IDLE, LOAD, START, RUN, CAPTURE, HOLD. Strobes are Moore outputs decoded from state.
- IDLE
  - in_ready=1.
  - On in_valid&in_ready, latch in_a/in_b into the operand registers.
  - If in_b==0: go to HOLD with out_q={WIDTH{1}}, out_ov=1, out_dz=1.
  - Otherwise: go to LOAD.
- div_A and div_B always drive the operand registers; they are stable from LOAD through CAPTURE.
- LOAD (1 cycle): div_ld_a=div_ld_b=div_clr=1. Next state START.
- START (1 cycle): div_start=1. Counter cleared to 0. Next state RUN.
- RUN
  - Counter increments each cycle.
  - On the cycle where counter==DIV_CYCLES-1, go to CAPTURE.
  - RUN therefore lasts exactly DIV_CYCLES cycles.
  - Counter width is clog2(DIV_CYCLES)+1. It does not wrap in normal operation.
- CAPTURE (1 cycle): at its closing edge, register out_q<=div_q, out_ov<=div_ov, out_dz<=0. Next state HOLD.
- HOLD
  - out_valid=1. out_q, out_ov and out_dz are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE.
- Latency, counting the accept edge as edge 0:
  - out_valid rises in cycle DIV_CYCLES+4 (18 at default).
  - Divide-by-zero: out_valid rises in cycle 1.
- Throughput:
  - in_ready is 1 only in IDLE, so at most one operation is in flight.
  - A result accepted in HOLD returns the block to IDLE. A new pair can be accepted the following cycle, giving one idle cycle minimum between results.
- Simultaneous events:
  - in_valid is ignored outside IDLE, with no latching.
  - out_ready is ignored outside HOLD.
  - in_a/in_b may change freely after acceptance.
- Reset mid-operation from any state:
  - Immediate return to IDLE; outputs cleared as at reset.
  - An in-flight divider operation is abandoned; the next LOAD's div_clr reinitialises the divider.
- out_valid never asserts without a preceding accepted pair. Exactly one result is produced per accepted pair.

Test Plan:
- Basic divide: in_a=10'd40, in_b=10'd8, out_ready=1.
  - Required: div_ld_a/div_ld_b/div_clr pulse in cycle 1 and div_start in cycle 2.
  - Required: out_valid in cycle 18; out_q equals the divider model result; out_ov=0; out_dz=0.
- Divide-by-zero: in_a=10'd5, in_b=0.
  - Required: no div_start; out_valid in cycle 1 with out_q=10'h3FF, out_ov=1, out_dz=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - Required: out_valid, out_q and out_ov stay stable; in_ready=0 and a new in_valid is not accepted.
  - Required: one cycle after out_ready=1, in_ready=1.
- Overflow pass-through: the divider model drives div_ov=1 (e.g. in_a=10'h3FF, in_b=1).
  - Required: out_ov=1, out_dz=0.
- Reset mid-RUN: assert rst at cycle 8 after accept.
  - Required: immediate busy=0, out_valid=0, in_ready=1 after release.
  - Required: the next pair completes normally in 18 cycles.
- Back-to-back: 3 pairs, with in_valid held high and out_ready=1.
  - Required: 3 results in order, separated by exactly DIV_CYCLES+5 cycles.

Source files
------------

// File: rtl/fixed_point_div_ctrl_if.sv
// Upstream/downstream handshake bundle for fixed_point_div_ctrl.
//   in_*  : operand pair request (valid/ready), dividend in_a, divisor in_b
//   out_* : result response (valid/ready), quotient out_q, flags out_ov/out_dz
// Modports: master = the side driving operands and taking results,
//           slave  = the controller.
interface fixed_point_div_ctrl_if #(
    parameter int WIDTH = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic             out_ov;
    logic             out_dz;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_q, out_ov, out_dz
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_q, out_ov, out_dz
    );
endinterface

// File: rtl/fixed_point_div_ctrl.sv
// Sequencer for the fixed-point divider datapath.
// Accepts an operand pair, loads/clears/starts the divider, waits the fixed
// iteration count, captures quotient/overflow and holds the result until the
// downstream side takes it. Divide-by-zero is answered locally.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   bus (slave)     in_valid/in_ready/in_a/in_b, out_valid/out_ready/out_q/out_ov/out_dz
//   div_A, div_B    operand registers to the divider
//   div_ld_a/ld_b   divider operand load strobes (LOAD)
//   div_clr         divider clear pulse (LOAD)
//   div_start       divider start pulse (START)
//   div_q, div_ov   divider quotient and overflow
//   busy            high whenever the controller is not idle
module fixed_point_div_ctrl #(
    parameter int WIDTH      = 10,
    parameter int DIV_CYCLES = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    fixed_point_div_ctrl_if.slave bus,
    output logic [WIDTH-1:0]     div_A,
    output logic [WIDTH-1:0]     div_B,
    output logic                 div_ld_a,
    output logic                 div_ld_b,
    output logic                 div_clr,
    output logic                 div_start,
    input  logic [WIDTH-1:0]     div_q,
    input  logic                 div_ov,
    output logic                 busy
);
    localparam int CW = $clog2(DIV_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, START, RUN, CAPTURE, HOLD
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  op_a, op_b;
    logic [WIDTH-1:0]  q_r;
    logic              ov_r, dz_r;
    logic [CW-1:0]     cnt;
    logic              accept;

    assign accept = bus.in_valid && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = (bus.in_b == '0) ? HOLD : LOAD;
            LOAD:    state_nxt = START;
            START:   state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = CAPTURE;
            CAPTURE: state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand, result and iteration-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
            q_r  <= '0;
            ov_r <= 1'b0;
            dz_r <= 1'b0;
            cnt  <= '0;
        end else begin
            if (accept) begin
                op_a <= bus.in_a;
                op_b <= bus.in_b;
                // Divide-by-zero skips the divider and saturates the result
                if (bus.in_b == '0) begin
                    q_r  <= '1;
                    ov_r <= 1'b1;
                    dz_r <= 1'b1;
                end
            end
            if (state == START) cnt <= '0;
            else if (state == RUN) cnt <= cnt + 1'b1;
            if (state == CAPTURE) begin
                q_r  <= div_q;
                ov_r <= div_ov;
                dz_r <= 1'b0;
            end
        end
    end

    // Moore decode of strobes and handshakes
    assign div_A         = op_a;
    assign div_B         = op_b;
    assign div_ld_a      = (state == LOAD);
    assign div_ld_b      = (state == LOAD);
    assign div_clr       = (state == LOAD);
    assign div_start     = (state == START);
    assign busy          = (state != IDLE);
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_q     = q_r;
    assign bus.out_ov    = ov_r;
    assign bus.out_dz    = dz_r;
endmodule
